// File: rtl/dec_reg_n_if.sv
// dec_reg_n_if: request/decode bundle between a requester (master) and dec_reg_n (slave).
// Latency: none, wiring only. Backpressure: in_ready from the slave throttles in_valid.
// Signals: in_valid/in_ready/sel/En/clr (request side), DataOut/out_valid/err (decode side),
//          err_cnt only when DEC_ERR_CNT_EN is defined.
interface dec_reg_n_if #(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   sel;
  logic               En;
  logic               clr;
  logic [NUM_OUT-1:0] DataOut;
  logic               out_valid;
  logic               err;
`ifdef DEC_ERR_CNT_EN
  logic [7:0]         err_cnt;
`endif

  modport master (
    output in_valid, sel, En, clr,
`ifdef DEC_ERR_CNT_EN
    input  err_cnt,
`endif
    input  in_ready, DataOut, out_valid, err
  );

  modport slave (
    input  in_valid, sel, En, clr,
`ifdef DEC_ERR_CNT_EN
    output err_cnt,
`endif
    output in_ready, DataOut, out_valid, err
  );
endinterface

// File: rtl/dec_reg_n.sv
// dec_reg_n: registered N-way one-hot decoder with optional level hold and post-accept lockout.
// Latency: 1 cycle from acceptance to DataOut/out_valid/err.
// Backpressure: in_ready drops for exactly LOCK cycles after each acceptance and during reset.
// Ports: clk, reset (synchronous, active-high), bus (dec_reg_n_if.slave).
// Optional feature: define DEC_ERR_CNT_EN to add the 8-bit saturating err_cnt output.
module dec_reg_n #(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32,
  parameter int HOLD    = 0,
  parameter int LOCK    = 0
) (
  input  logic        clk,
  input  logic        reset,
  dec_reg_n_if.slave  bus
);

  localparam logic [3:0] LOCK_C = 4'(LOCK);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ready;
  logic               accept;
  logic               in_range;
  logic               err_d;
  logic [NUM_OUT-1:0] dec;
  logic [NUM_OUT-1:0] data_q, data_d;
  logic               out_valid_q;
  logic               err_q;

  // Ready is gated by reset so nothing presented during reset can be taken.
  assign ready  = (state_q == IDLE) && !reset;
  assign accept = bus.in_valid && ready;

  // Lockout FSM: next state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && (LOCK_C != 4'd0)) begin
          state_d = LOCKED;
          cnt_d   = LOCK_C;
        end
      end
      LOCKED: begin
        // cnt_q counts LOCK..1 across the locked cycles; leaving on 1 gives
        // exactly LOCK cycles with in_ready low.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Decode only indices below NUM_OUT; anything else leaves in_range low.
  always_comb begin
    dec      = '0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        in_range = 1'b1;
        dec[i]   = bus.En;
      end
    end
  end

  assign err_d = accept && bus.En && !in_range;

  // Acceptance beats clr; in pulse mode the output falls back to zero every
  // idle cycle, so clr has nothing to act on.
  always_comb begin
    data_d = '0;
    if (accept) begin
      data_d = dec;
    end else if ((HOLD != 0) && !bus.clr) begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_valid_q <= accept;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.DataOut   = data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;

`ifdef DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Counts alongside the err strobe it accompanies; sticks at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  // A strobe never carries more than one decoded bit.
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    out_valid_q |-> $onehot0(data_q));

  // Error strobes only ever accompany a valid strobe with an all-zero decode.
  a_err_zero: assert property (@(posedge clk) disable iff (reset)
    err_q |-> (out_valid_q && (data_q == '0)));

endmodule

// File: tb/tb_dec_reg_n.sv
// tb_dec_reg_n: scoreboard bench for dec_reg_n with two instances.
// u0: defaults (32 outputs, pulse mode, no lockout). u1: 20 outputs, level mode, LOCK=2.
// Drivers push expected strobes into per-instance queues; negedge monitors pop and compare.
module tb_dec_reg_n;

  localparam int LOCK1 = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dec_reg_n_if #(.SEL_W(5), .NUM_OUT(32)) if0 ();
  dec_reg_n_if #(.SEL_W(5), .NUM_OUT(20)) if1 ();

  dec_reg_n #(.SEL_W(5), .NUM_OUT(32), .HOLD(0), .LOCK(0)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  dec_reg_n #(.SEL_W(5), .NUM_OUT(20), .HOLD(1), .LOCK(LOCK1)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc    = 0;
  int          passed = 0;
  int          total  = 0;
  bit          mon_en = 1'b0;
  int          lk1    = 0;
  logic [19:0] hold1  = '0;
  int          ecnt1  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // u0 never locks, so every request is accepted in the cycle it is driven.
  task automatic drive0(input bit v, input logic [4:0] s, input bit en, input bit c,
                        input logic [31:0] exp_d);
    exp_t e;
    if0.in_valid = v;
    if0.sel      = s;
    if0.En       = en;
    if0.clr      = c;
    if (v) begin
      e.due  = cyc + 1;
      e.data = exp_d;
      e.err  = 1'b0;
      q0.push_back(e);
    end
    @(negedge clk);
    chk("u0_in_ready", 64'(if0.in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // u1 readiness, held value and error count come from the bench's own model.
  task automatic drive1(input bit v, input logic [4:0] s, input bit en, input bit c,
                        input logic [19:0] exp_d, input bit exp_e, output bit acc);
    exp_t e;
    bit   rdy;
    rdy          = (lk1 == 0);
    if1.in_valid = v;
    if1.sel      = s;
    if1.En       = en;
    if1.clr      = c;
    acc          = v && rdy;
    if (acc) begin
      e.due  = cyc + 1;
      e.data = 32'(exp_d);
      e.err  = exp_e;
      q1.push_back(e);
    end
    @(negedge clk);
    chk("u1_in_ready", 64'(if1.in_ready), 64'(rdy));
    @(posedge clk);
    #1;
    if (acc) begin
      lk1   = LOCK1;
      hold1 = exp_d;
      if (exp_e && ecnt1 < 255) ecnt1++;
    end else begin
      if (lk1 > 0) lk1--;
      if (c) hold1 = '0;
    end
  endtask

  // Keep in_valid high until the model says the request was taken.
  task automatic send1(input logic [4:0] s, input bit en, input bit c,
                       input logic [19:0] exp_d, input bit exp_e);
    bit a;
    a = 1'b0;
    while (!a) drive1(1'b1, s, en, c, exp_d, exp_e, a);
  endtask

  task automatic idle1(input int n);
    bit a;
    repeat (n) drive1(1'b0, 5'd0, 1'b0, 1'b0, 20'h0, 1'b0, a);
  endtask

  // Requests are presented throughout reset and must leave no trace.
  task automatic do_reset(input int n);
    reset        = 1'b1;
    if0.in_valid = 1'b1; if0.sel = 5'd7; if0.En = 1'b1; if0.clr = 1'b0;
    if1.in_valid = 1'b1; if1.sel = 5'd7; if1.En = 1'b1; if1.clr = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_u0_in_ready", 64'(if0.in_ready), 64'd0);
      chk("rst_u1_in_ready", 64'(if1.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    reset        = 1'b0;
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    lk1          = 0;
    hold1        = '0;
    ecnt1        = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (if0.out_valid === 1'b1) begin
        if (q0.size() == 0) begin
          chk("u0_out_valid_unexpected", 64'(if0.out_valid), 64'd0);
        end else begin
          e = q0.pop_front();
          chk("u0_latency", 64'(cyc), 64'(e.due));
          chk("u0_dataout", 64'(if0.DataOut), 64'(e.data));
          chk("u0_err", 64'(if0.err), 64'(e.err));
        end
      end else begin
        chk("u0_out_valid_idle", 64'(if0.out_valid), 64'd0);
        chk("u0_dataout_idle", 64'(if0.DataOut), 64'd0);
        chk("u0_err_idle", 64'(if0.err), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("u1_dataout_level", 64'(if1.DataOut), 64'(hold1));
`ifdef DEC_ERR_CNT_EN
      chk("u1_err_cnt", 64'(if1.err_cnt), 64'(ecnt1));
`endif
      if (if1.out_valid === 1'b1) begin
        if (q1.size() == 0) begin
          chk("u1_out_valid_unexpected", 64'(if1.out_valid), 64'd0);
        end else begin
          e = q1.pop_front();
          chk("u1_latency", 64'(cyc), 64'(e.due));
          chk("u1_dataout", 64'(if1.DataOut), 64'(e.data));
          chk("u1_err", 64'(if1.err), 64'(e.err));
        end
      end else begin
        chk("u1_out_valid_idle", 64'(if1.out_valid), 64'd0);
        chk("u1_err_idle", 64'(if1.err), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    if0.in_valid = 1'b0; if0.sel = '0; if0.En = 1'b0; if0.clr = 1'b0;
    if1.in_valid = 1'b0; if1.sel = '0; if1.En = 1'b0; if1.clr = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset(3);

    // Reset state of both instances.
    @(negedge clk);
    chk("rst_u0_dataout", 64'(if0.DataOut), 64'd0);
    chk("rst_u0_out_valid", 64'(if0.out_valid), 64'd0);
    chk("rst_u0_err", 64'(if0.err), 64'd0);
    chk("rst_u0_in_ready_after", 64'(if0.in_ready), 64'd1);
    chk("rst_u1_dataout", 64'(if1.DataOut), 64'd0);
    chk("rst_u1_out_valid", 64'(if1.out_valid), 64'd0);
    chk("rst_u1_err", 64'(if1.err), 64'd0);
    chk("rst_u1_in_ready_after", 64'(if1.in_ready), 64'd1);
`ifdef DEC_ERR_CNT_EN
    chk("rst_u0_err_cnt", 64'(if0.err_cnt), 64'd0);
    chk("rst_u1_err_cnt", 64'(if1.err_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // u0 pulse mode: sel=5 strobes 0x20 for one cycle, then zero.
    drive0(1'b1, 5'd5,  1'b1, 1'b0, 32'h0000_0020);
    drive0(1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    drive0(1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    // En=0 decodes to zero; clr has no effect in pulse mode.
    drive0(1'b1, 5'd9,  1'b0, 1'b0, 32'h0);
    drive0(1'b1, 5'd31, 1'b1, 1'b1, 32'h8000_0000);
    drive0(1'b0, 5'd0,  1'b0, 1'b1, 32'h0);
    drive0(1'b1, 5'd0,  1'b1, 1'b0, 32'h0000_0001);
    drive0(1'b0, 5'd0,  1'b0, 1'b0, 32'h0);

    // u0 back-to-back sweep of every index with En alternating.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] want;
      want = ((i % 2) == 0) ? (32'd1 << i) : 32'd0;
      drive0(1'b1, 5'(i), ((i % 2) == 0), 1'b0, want);
    end
    drive0(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);

    // u1 range boundaries: 19 is the top output, 20 and 25 are errors,
    // out-of-range with En=0 is not an error.
    send1(5'd25, 1'b1, 1'b0, 20'h0,       1'b1);
    send1(5'd19, 1'b1, 1'b0, 20'h8_0000,  1'b0);
    send1(5'd20, 1'b1, 1'b0, 20'h0,       1'b1);
    send1(5'd0,  1'b1, 1'b0, 20'h0_0001,  1'b0);
    send1(5'd25, 1'b0, 1'b0, 20'h0,       1'b0);
    idle1(3);

    // u1 lockout: in_valid held, sel stepping 0,1,2; taken every third cycle.
    send1(5'd0, 1'b1, 1'b0, 20'h0_0001, 1'b0);
    send1(5'd1, 1'b1, 1'b0, 20'h0_0002, 1'b0);
    send1(5'd2, 1'b1, 1'b0, 20'h0_0004, 1'b0);
    idle1(3);

    // u1 level mode: hold 0x8, acceptance beats clr, clr alone clears.
    send1(5'd3, 1'b1, 1'b0, 20'h0_0008, 1'b0);
    idle1(5);
    send1(5'd1, 1'b1, 1'b1, 20'h0_0002, 1'b0);
    idle1(3);
    begin
      bit a;
      drive1(1'b0, 5'd0, 1'b0, 1'b1, 20'h0, 1'b0, a);
    end
    idle1(2);

    // u1 reset during the first locked cycle aborts the lockout.
    send1(5'd4, 1'b1, 1'b0, 20'h0_0010, 1'b0);
    do_reset(1);
    send1(5'd6, 1'b1, 1'b0, 20'h0_0040, 1'b0);
    idle1(3);

`ifdef DEC_ERR_CNT_EN
    // Error counter saturation.
    repeat (300) send1(5'd25, 1'b1, 1'b0, 20'h0, 1'b1);
    idle1(3);
    chk("u1_err_cnt_saturated", 64'(if1.err_cnt), 64'd255);
    chk("u0_err_cnt_quiet", 64'(if0.err_cnt), 64'd0);
`endif

    idle1(2);
    chk("u0_queue_drained", 64'(q0.size()), 64'd0);
    chk("u1_queue_drained", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dec_reg_n.md
DEC_REG_N -- requirements
Module: dec_reg_n

Interface
REQ-001 Parameter SEL_W, default 5, select width in bits.
REQ-002 Parameter NUM_OUT, default 32, number of decoded outputs; legal range 2..2**SEL_W.
REQ-003 Parameter HOLD, default 0; 0 = pulse mode, 1 = level mode.
REQ-004 Parameter LOCK, default 0, lockout cycles after each accepted request; legal range 0..15.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request this cycle.
REQ-009 sel  input  SEL_W  output index to decode.
REQ-010 En  input  1  enable; when 0, an accepted request decodes to all-zero.
REQ-011 clr  input  1  clears held DataOut (level mode only).
REQ-012 DataOut  output  NUM_OUT  registered one-hot or all-zero decode.
REQ-013 out_valid  output  1  one-cycle strobe: DataOut reflects a newly accepted request.
REQ-014 err  output  1  one-cycle strobe: accepted request had sel >= NUM_OUT with En=1.
REQ-015 err_cnt  output  8  saturating out-of-range count (present only with DEC_ERR_CNT_EN).

Function
REQ-016 A request SHALL be accepted in a cycle where in_valid=1 and in_ready=1.
REQ-017 Latency SHALL be exactly 1 cycle: DataOut, out_valid, err update on the posedge after acceptance.
REQ-018 For an accepted request with En=1 and sel < NUM_OUT, DataOut SHALL have exactly bit sel set.
REQ-019 For an accepted request with En=0, DataOut SHALL be all-zero, out_valid=1, err=0, regardless of sel.
REQ-020 For an accepted request with En=1 and sel >= NUM_OUT, DataOut SHALL be all-zero, out_valid=1, err=1.
REQ-021 Pulse mode: in any cycle not immediately following an acceptance, DataOut SHALL be all-zero; clr SHALL be ignored.
REQ-022 Level mode: DataOut SHALL hold its last value until the next acceptance or clr=1; clr zeroes DataOut on the next posedge.
REQ-023 Level mode, clr=1 in the same cycle as an acceptance: the acceptance SHALL win and DataOut takes the new decode.
REQ-024 out_valid and err SHALL be 0 in every cycle not immediately following an acceptance, in both modes.
REQ-025 FSM: IDLE (in_ready=1) and LOCKED (in_ready=0); acceptance with LOCK>0 moves IDLE->LOCKED and loads a 4-bit counter with LOCK.
REQ-026 In LOCKED the counter SHALL decrement each cycle; on the cycle it would reach 0 the FSM returns to IDLE, giving exactly LOCK cycles of in_ready=0.
REQ-027 With LOCK=0 the FSM SHALL stay in IDLE and accept one request every cycle (back-to-back).
REQ-028 Requests with in_valid=1 while in_ready=0 SHALL be ignored with no state change; the requester holds them.
REQ-029 Error and En=0 requests SHALL still start the lockout.

Reset
REQ-030 While reset=1, in_ready SHALL be 0; on the first cycle after deassertion it SHALL be 1.
REQ-031 Reset SHALL force DataOut=0, out_valid=0, err=0, FSM=IDLE, counter=0, err_cnt=0.
REQ-032 Reset asserted mid-lockout SHALL abort the lockout; no request accepted during reset takes effect.

Configuration
REQ-033 Macro DEC_ERR_CNT_EN: when defined, err_cnt exists and increments by 1 on each err strobe, saturating at 255, cleared only by reset.
REQ-034 Without DEC_ERR_CNT_EN, the err_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Defaults, pulse mode: sel=5,En=1 accepted at cycle 0 -> DataOut=0x00000020,out_valid=1 at cycle 1, DataOut=0 at cycle 2.
REQ-036 NUM_OUT=20: sel=25,En=1 -> DataOut=0, err=1, out_valid=1 next cycle; with DEC_ERR_CNT_EN, err_cnt 0->1; 300 such requests -> err_cnt=255.
REQ-037 HOLD=1: sel=3 accepted, then idle 5 cycles -> DataOut stays 0x8; clr=1 alongside acceptance of sel=1 -> DataOut=0x2; clr alone -> DataOut=0.
REQ-038 LOCK=2: in_valid held high with sel stepping 0,1,2 -> accepted at cycles 0,3,6; in_ready=0 cycles 1-2 and 4-5.
REQ-039 LOCK=3: reset=1 during cycle 1 of lockout -> DataOut=0, in_ready=0 during reset, in_ready=1 first cycle after deassert.
REQ-040 LOCK=0: sel=0..31 back-to-back with En toggling -> each cycle one-hot bit sel when En=1, zero when En=0, out_valid=1 throughout.
